// File: rtl/regwr_scoreboard.sv
// Register write scoreboard: per-register pending-write counters with a combinational ID-stage stall query.
// Define SCOREBOARD_BYPASS_EN to let a same-cycle final writeback release the busy flag.
module regwr_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iss_valid,
  input  logic [4:0] iss_wr,
  output logic       iss_ready,
  input  logic       ret_valid,
  input  logic [4:0] ret_wr,
  input  logic       flush,
  input  logic [4:0] RR1,
  input  logic [4:0] RR2,
  input  logic       use_rs,
  input  logic       use_rt,
  output logic       rs_busy,
  output logic       rt_busy,
  output logic       stall_out,
  output logic [6:0] inflight,
  output logic       err_underflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [6:0]       inflight_q, inflight_d;
  logic             err_q, err_d;
  logic [NREG-1:0]  inc_s, dec_s;
  logic             rs_byp_s, rt_byp_s;

  // Issue acceptance: a saturated counter still accepts when one of its writes retires now
  always_comb begin
    iss_ready = 1'b1;
    if ((iss_wr != 5'd0) && (cnt_q[iss_wr] == CNT_MAX) &&
        !(ret_valid && (ret_wr == iss_wr))) begin
      iss_ready = 1'b0;
    end else begin
      iss_ready = 1'b1;
    end
  end

  // Next-state for counters, inflight total and sticky underflow flag
  always_comb begin
    inc_s      = {NREG{1'b0}};
    dec_s      = {NREG{1'b0}};
    inflight_d = inflight_q;
    err_d      = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < NREG; r++) begin
      inc_s[r] = iss_valid & iss_ready & (iss_wr == 5'(r));
      dec_s[r] = ret_valid & (ret_wr == 5'(r)) & (cnt_q[r] != CNT_ZERO);
      case ({inc_s[r], dec_s[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
    case ({|inc_s, |dec_s})
      2'b10:   inflight_d = inflight_q + 7'd1;
      2'b01:   inflight_d = inflight_q - 7'd1;
      default: inflight_d = inflight_q;
    endcase
    if (ret_valid && (ret_wr != 5'd0) && (cnt_q[ret_wr] == CNT_ZERO)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    // Flush cancels every in-flight write but keeps the error history
    if (flush) begin
      inflight_d = 7'd0;
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = CNT_ZERO;
      end
    end else begin
      inflight_d = inflight_d;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      inflight_q <= 7'd0;
      err_q      <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Same-cycle writeback release of the final pending write
  always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
    rs_byp_s = ret_valid & (ret_wr == RR1) & (cnt_q[RR1] == CNT_ONE);
    rt_byp_s = ret_valid & (ret_wr == RR2) & (cnt_q[RR2] == CNT_ONE);
`else
    rs_byp_s = 1'b0;
    rt_byp_s = 1'b0;
`endif
  end

  // ID-stage query and stall decision
  always_comb begin
    rs_busy   = (RR1 != 5'd0) & (cnt_q[RR1] != CNT_ZERO) & ~rs_byp_s;
    rt_busy   = (RR2 != 5'd0) & (cnt_q[RR2] != CNT_ZERO) & ~rt_byp_s;
    stall_out = (use_rs & rs_busy) | (use_rt & rt_busy) | (iss_valid & ~iss_ready);
  end

  assign inflight      = inflight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_regwr_scoreboard.sv
// Scoreboard bench for regwr_scoreboard: directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_regwr_scoreboard;

  logic       clk, rst;
  logic       iss_valid, ret_valid, flush, use_rs, use_rt;
  logic [4:0] iss_wr, ret_wr, RR1, RR2;
  logic       iss_ready, rs_busy, rt_busy, stall_out, err_underflow;
  logic [6:0] inflight;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic       ers, ert, erdy, estall;
    logic [6:0] einfl;
    logic       eerr;
  } exp_t;
  exp_t exp_q[$];

  regwr_scoreboard dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_ready(iss_ready),
    .ret_valid(ret_valid), .ret_wr(ret_wr), .flush(flush),
    .RR1(RR1), .RR2(RR2), .use_rs(use_rs), .use_rt(use_rt),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .stall_out(stall_out),
    .inflight(inflight), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string fld, input logic [6:0] act, input logic [6:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s.%s got=%0d expected=%0d", name, fld, act, expv);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    int   sum;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "rs_busy",   7'(rs_busy),       7'(e.ers));
      chk(e.name, "rt_busy",   7'(rt_busy),       7'(e.ert));
      chk(e.name, "iss_ready", 7'(iss_ready),     7'(e.erdy));
      chk(e.name, "stall_out", 7'(stall_out),     7'(e.estall));
      chk(e.name, "inflight",  inflight,          e.einfl);
      chk(e.name, "err",       7'(err_underflow), 7'(e.eerr));
      sum = 0;
      for (int i = 1; i < 32; i++) sum += int'(dut.cnt_q[i]);
      chk(e.name, "sum_cnt", 7'(sum), inflight);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected for it
  task automatic vec(input string name,
                     input logic iv, input logic [4:0] iw, input logic rv, input logic [4:0] rw,
                     input logic fl, input logic [4:0] r1, input logic [4:0] r2,
                     input logic us, input logic ut,
                     input logic ers, input logic ert, input logic erdy, input logic estall,
                     input logic [6:0] einfl, input logic eerr);
    exp_t e;
    iss_valid = iv; iss_wr = iw; ret_valid = rv; ret_wr = rw; flush = fl;
    RR1 = r1; RR2 = r2; use_rs = us; use_rt = ut;
    e.name = name; e.ers = ers; e.ert = ert; e.erdy = erdy; e.estall = estall;
    e.einfl = einfl; e.eerr = eerr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic byp;

  initial begin
`ifdef SCOREBOARD_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rst = 1'b1;
    iss_valid = 1'b0; iss_wr = 5'd0; ret_valid = 1'b0; ret_wr = 5'd0; flush = 1'b0;
    RR1 = 5'd0; RR2 = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    //   name        iv  iw     rv  rw     fl  RR1    RR2    us  ut   rs  rt  rdy st  infl  err
    vec("reset",    0, 5'd0,  0, 5'd0,  0, 5'd5,  5'd0,  1, 0,   0, 0, 1, 0,   7'd0, 0);
    vec("iss5",     1, 5'd5,  0, 5'd0,  0, 5'd5,  5'd0,  1, 0,   0, 0, 1, 0,   7'd0, 0);
    vec("busy5a",   0, 5'd0,  0, 5'd0,  0, 5'd5,  5'd0,  1, 0,   1, 0, 1, 1,   7'd1, 0);
    vec("busy5b",   0, 5'd0,  0, 5'd0,  0, 5'd5,  5'd0,  1, 0,   1, 0, 1, 1,   7'd1, 0);
    vec("ret5",     0, 5'd0,  1, 5'd5,  0, 5'd5,  5'd0,  1, 0,  ~byp, 0, 1, ~byp, 7'd1, 0);
    vec("free5",    0, 5'd0,  0, 5'd0,  0, 5'd5,  5'd0,  1, 0,   0, 0, 1, 0,   7'd0, 0);
    vec("iss7a",    1, 5'd7,  0, 5'd0,  0, 5'd0,  5'd7,  0, 1,   0, 0, 1, 0,   7'd0, 0);
    vec("iss7b",    1, 5'd7,  0, 5'd0,  0, 5'd0,  5'd7,  0, 1,   0, 1, 1, 1,   7'd1, 0);
    vec("iss7c",    1, 5'd7,  0, 5'd0,  0, 5'd0,  5'd0,  0, 0,   0, 0, 1, 0,   7'd2, 0);
    vec("sat7",     1, 5'd7,  0, 5'd0,  0, 5'd0,  5'd7,  0, 0,   0, 1, 0, 1,   7'd3, 0);
    vec("sat7ret",  1, 5'd7,  1, 5'd7,  0, 5'd0,  5'd7,  0, 1,   0, 1, 1, 1,   7'd3, 0);
    vec("still7",   0, 5'd0,  0, 5'd0,  0, 5'd0,  5'd7,  0, 0,   0, 1, 1, 0,   7'd3, 0);
    vec("flushA",   0, 5'd0,  0, 5'd0,  1, 5'd0,  5'd7,  0, 0,   0, 1, 1, 0,   7'd3, 0);
    vec("iss3",     1, 5'd3,  0, 5'd0,  0, 5'd0,  5'd7,  0, 0,   0, 0, 1, 0,   7'd0, 0);
    vec("iss4",     1, 5'd4,  0, 5'd0,  0, 5'd0,  5'd0,  0, 0,   0, 0, 1, 0,   7'd1, 0);
    vec("iss9",     1, 5'd9,  0, 5'd0,  0, 5'd3,  5'd4,  1, 1,   1, 1, 1, 1,   7'd2, 0);
    vec("flushB",   1, 5'd10, 0, 5'd0,  1, 5'd9,  5'd10, 1, 1,   1, 0, 1, 1,   7'd3, 0);
    vec("postfl1",  0, 5'd0,  0, 5'd0,  0, 5'd9,  5'd10, 1, 1,   0, 0, 1, 0,   7'd0, 0);
    vec("postfl2",  0, 5'd0,  0, 5'd0,  0, 5'd3,  5'd4,  1, 1,   0, 0, 1, 0,   7'd0, 0);
    vec("under12",  0, 5'd0,  1, 5'd12, 0, 5'd12, 5'd0,  1, 0,   0, 0, 1, 0,   7'd0, 0);
    vec("errset",   0, 5'd0,  0, 5'd0,  0, 5'd12, 5'd0,  1, 0,   0, 0, 1, 0,   7'd0, 1);
    vec("errflush", 0, 5'd0,  0, 5'd0,  1, 5'd0,  5'd0,  0, 0,   0, 0, 1, 0,   7'd0, 1);
    vec("zero_iss", 1, 5'd0,  1, 5'd0,  0, 5'd0,  5'd0,  1, 1,   0, 0, 1, 0,   7'd0, 1);
    vec("zero_chk", 0, 5'd0,  0, 5'd0,  0, 5'd0,  5'd0,  1, 1,   0, 0, 1, 0,   7'd0, 1);
    vec("iss5b",    1, 5'd5,  0, 5'd0,  0, 5'd0,  5'd0,  0, 0,   0, 0, 1, 0,   7'd0, 1);
    vec("busy5c",   0, 5'd0,  0, 5'd0,  0, 5'd5,  5'd0,  1, 0,   1, 0, 1, 1,   7'd1, 1);
    // Asynchronous reset pulse between clock edges
    rst = 1'b1;
    #1 rst = 1'b0;
    vec("arst",     0, 5'd0,  0, 5'd0,  0, 5'd5,  5'd0,  1, 0,   0, 0, 1, 0,   7'd0, 0);
    vec("idle",     0, 5'd0,  0, 5'd0,  0, 5'd5,  5'd5,  1, 1,   0, 0, 1, 0,   7'd0, 0);
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regwr_scoreboard.md
Name: regwr_scoreboard

Overview:
- Producer-side counterpart to the ID-stage stall check.
- Tracks architectural destination registers that have issued from ID but not yet written back. Multi-cycle ops (mul/div, loads) occupy a register for a variable number of cycles.
- Takes issue and writeback events from the pipeline and drives registered busy state.
- The ID stage queries it with rs/rt numbers and gets a single stall decision. Replaces fixed EXE/MEM compares when producer latency is variable.

Parameters:
- CNT_W, default 2: width of each per-register pending counter. A register may have up to 2^CNT_W-1 writes in flight.
- NREG, default 32: number of architectural registers. Register 0 is never tracked.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- iss_valid  input  1  ID issues an instruction that writes a register
- iss_wr  input  5  destination register of the issuing instruction
- iss_ready  output  1  issue accepted this cycle (pending counter not saturated)
- ret_valid  input  1  WB stage writes a register this cycle
- ret_wr  input  5  register written back
- flush  input  1  pipeline flush; all in-flight writes are cancelled
- RR1  input  5  rs read-register number from ID
- RR2  input  5  rt read-register number from ID
- use_rs  input  1  ID instruction reads rs
- use_rt  input  1  ID instruction reads rt
- rs_busy  output  1  RR1 has a pending write
- rt_busy  output  1  RR2 has a pending write
- stall_out  output  1  (use_rs & rs_busy) | (use_rt & rt_busy) | (iss_valid & ~iss_ready)
- inflight  output  7  total pending writes across all registers (registered)
- err_underflow  output  1  sticky: retire seen for a register with zero pending writes

Behaviour:
- State is cnt[1..NREG-1], each CNT_W bits, plus inflight and err_underflow.
- Reset (async): all cnt=0, inflight=0, err_underflow=0.
  - Hence rs_busy=rt_busy=0, iss_ready=1, stall_out=use-independent 0.
- inc[r] = iss_valid & iss_ready & (iss_wr==r) & (r!=0).
- dec[r] = ret_valid & (ret_wr==r) & (r!=0) & (cnt[r]!=0).
- Next cnt[r] = cnt[r] + inc[r] - dec[r].
  - Simultaneous inc and dec on the same register leaves cnt unchanged.
- Next inflight = inflight + |inc - |dec.
  - Also equals the sum of cnt; the bench checks this invariant every cycle.
- iss_ready = (iss_wr==0) | (cnt[iss_wr] != MAX) | (ret_valid & ret_wr==iss_wr).
  - A saturated register accepts a new issue in the same cycle one of its writes retires.
- Issue to $0 is always ready and changes no state.
- Retire of $0 is ignored silently.
- Retire of register r with cnt[r]==0 changes no counters and sets err_underflow on the next edge. err_underflow clears only on rst.
- flush (synchronous) clears all cnt and inflight on the next edge.
  - Overrides any issue or retire in the same cycle.
  - Does not clear err_underflow.
  - iss_ready is unaffected during the flush cycle.
- Query path is combinational from registered state:
  - rs_busy = (RR1!=0) & (cnt[RR1]!=0)
  - rt_busy = (RR2!=0) & (cnt[RR2]!=0)
- Latency: an issue at edge N makes the register busy from cycle N+1. A retire at edge N clears busy from cycle N+1 when cnt was 1.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Optional Feature:
- Macro SCOREBOARD_BYPASS_EN.
- Defined: the query includes the same-cycle retire.
  - rs_busy = (RR1!=0) & (cnt[RR1]!=0) & ~(ret_valid & ret_wr==RR1 & cnt[RR1]==1). rt_busy likewise.
  - A consumer reading a register written back this cycle does not stall; WB-to-ID forwarding or write-first regfile is required.
- Undefined: busy reflects registered cnt only, giving one extra stall cycle on the final writeback.

Test Plan:
- Reset, then RR1=5, use_rs=1, no issue -> rs_busy=0, stall_out=0, inflight=0.
- Issue iss_wr=5 at cycle 1; RR1=5, use_rs=1 -> stall_out=1 from cycle 2. ret_wr=5 at cycle 4 -> stall_out=0 from cycle 5 (cycle 4 with SCOREBOARD_BYPASS_EN).
- Issue r7 three times (CNT_W=2) -> cnt=3, iss_valid with iss_wr=7 gives iss_ready=0, stall_out=1. Same cycle ret_wr=7 -> iss_ready=1, cnt stays 3.
- Issue r3, r4, r9; flush together with issue of r10 -> next cycle inflight=0, all busy=0, r10 not recorded.
- ret_valid, ret_wr=12 with cnt[12]=0 -> counters unchanged, err_underflow=1 next cycle, still 1 after flush, 0 after rst.
- Issue and query $0 (iss_wr=0, RR1=0, RR2=0, use_rs=use_rt=1) -> iss_ready=1, rs_busy=rt_busy=0, inflight unchanged.
